base3_chunk_feeder: RTL
=======================

Name: base3_chunk_feeder

Overview:
- Controller that sequences the shared base2_to_base3 converter for the hiding-string encode phase.
- Splits the 4096-bit hiding string into 256 chunks of 16 bits, drives the converter once per chunk, and prefetches results into a two-entry buffer.
- The encode FSM pops one 32-bit base-3 word per 4x4 block, so conversion overlaps pixel encoding.
- Sits between the top-level process FSM (start, hiding_string) and the converter instance.

Parameters:
STR_BITS, 4096, hiding-string width in bits.
CHUNK_W, 16, bits per chunk fed to the converter.
OUT_W, 32, base-3 result width (2 bits per ternary digit).
N_CHUNKS, STR_BITS/CHUNK_W (256), chunks per image; equals the number of 4x4 blocks in a 64x64 image.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; (re)starts the feed from chunk 0.
hiding_string  in  STR_BITS  string to encode; sampled live, must be stable from start until exhausted.
conv_en  out  1  converter enable.
conv_in  out  CHUNK_W  converter operand, hiding_string[ptr*CHUNK_W +: CHUNK_W].
conv_done  in  1  converter done, one-cycle pulse.
conv_out  in  OUT_W  converter result, valid while conv_done=1.
chunk_req  in  1  consumer pop; one pulse per block.
chunk_valid  out  1  head entry valid.
chunk_data  out  OUT_W  head entry.
chunk_idx  out  8  index (0..255) of head entry.
busy  out  1  feed active (start seen, not exhausted).
exhausted  out  1  all N_CHUNKS converted and popped.
underrun  out  1  sticky; chunk_req seen with chunk_valid=0.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; ptr=0, count=0, nothing in flight. FSM goes to IDLE. conv_en drops in the same instant as reset, even mid-conversion.
- FSM states:
  - IDLE: wait for start; start -> LAUNCH. Clears ptr, buffer, chunk_idx, exhausted and underrun.
  - LAUNCH: conv_en=1, conv_in from ptr. Stays until conv_done=1. Converting at most one chunk at a time.
  - CAPTURE: one cycle. conv_en=0; conv_out is written to the buffer tail on the conv_done edge; ptr++. Then:
    - -> GAP if ptr<N_CHUNKS and count<=1 after this cycle's pop/push;
    - -> HOLD if count=2;
    - -> DRAIN if ptr=N_CHUNKS.
  - GAP: one cycle with conv_en=0, giving the converter a clean rising edge; -> LAUNCH.
  - HOLD: conv_en=0 until count<=1 (a pop); -> LAUNCH on the next cycle.
  - DRAIN: no conversions. When count=0 -> DONE.
  - DONE: exhausted=1, busy=0. Holds until start or reset.
- Overflow impossible by construction: launch only when count<=1, and only one conversion is in flight.
- Latency: chunk_valid rises the cycle after conv_done is sampled with an empty buffer.
- Pop handshake:
  - chunk_req with chunk_valid=1 removes the head; the next entry (or chunk_valid=0) appears the next cycle.
  - chunk_idx increments by 1 per pop.
- Same-cycle pop and capture: both take effect and count is unchanged. With count=0, the pop is an underrun: the captured word is still stored, and underrun is set.
- chunk_req with chunk_valid=0 (including IDLE/DONE): ignored, underrun<=1 (sticky until start/reset).
- start while busy: abort.
  - conv_en is forced 0 for one cycle.
  - Any conv_done from the aborted conversion arriving in that cycle is discarded.
  - Then restart at chunk 0 (IDLE clear actions applied).
- busy = state not in {IDLE, DONE}.
- Data: chunk_data is exactly conv_out as captured, no re-packing. Digit n occupies bits [2n+1:2n].

Decomposition:
- Shared package: STR_BITS, CHUNK_W, OUT_W, N_CHUNKS, FSM state encoding. Reused by the encode FSM for its digit index and block count.
- One sub-module: chunk_buf2, a two-entry FIFO with push/pop/count and same-cycle push+pop support. The FSM and pointer live in base3_chunk_feeder.

Test Plan:
- Reset mid-LAUNCH: rst_n low while conv_en=1 -> conv_en=0 immediately; all outputs 0; no capture on a later conv_done.
- Single chunk value: hiding_string[15:0]=16'h0005 (5 = 12 in base 3), start, behavioural converter with 10-cycle latency -> chunk_valid=1 one cycle after conv_done, chunk_data=32'h00000006, chunk_idx=0.
- Prefetch/backpressure: no pops after start -> exactly two conversions, then HOLD with conv_en=0. One pop -> conv_en rises within 2 cycles; conv_in = hiding_string[47:32].
- Full run: pop each word 5 cycles after chunk_valid -> 256 pops, chunk_idx 0..255, each word matches the model. exhausted=1 after pop 256; conv_en stays 0 afterwards.
- Underrun/simultaneous: pop with chunk_valid=0 -> underrun=1 sticky, count unchanged. Pop coinciding with capture at count=1 -> count stays 1, order preserved.
- Restart: start pulse at chunk 100 -> conv_en low 1 cycle; next conv_in = hiding_string[15:0]; chunk_idx=0; underrun cleared.

Source files
------------

// File: rtl/base3_chunk_feeder_pkg.sv
// Shared sizing and FSM encoding for the hiding-string base-3 feed.
// Also used by the encode FSM for its digit index and block count.
package base3_chunk_feeder_pkg;

    localparam int STR_BITS = 4096;
    localparam int CHUNK_W  = 16;
    localparam int OUT_W    = 32;
    localparam int N_CHUNKS = STR_BITS / CHUNK_W;
    localparam int IDX_W    = $clog2(N_CHUNKS);
    localparam int PTR_W    = IDX_W + 1;

    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(N_CHUNKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_CAPTURE,
        S_GAP,
        S_HOLD,
        S_DRAIN,
        S_DONE,
        S_ABORT
    } feed_state_t;

endpackage

// File: rtl/base3_chunk_feeder_buf2.sv
// Two-entry FIFO holding prefetched base-3 words.
// Push and pop may coincide; a push into a full buffer needs a same-cycle pop.
module chunk_buf2
    import base3_chunk_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [OUT_W-1:0] din,
    output logic             valid,
    output logic [OUT_W-1:0] dout,
    output logic [1:0]       count
);

    logic [OUT_W-1:0] mem [2];
    logic             head;
    logic             tail;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign tail    = head ^ count[0];
    assign valid   = (count != 2'd0);
    assign dout    = mem[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            count  <= 2'd0;
        end else if (clr) begin
            head   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) mem[tail] <= din;
            if (do_pop)  head      <= ~head;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/base3_chunk_feeder.sv
// Sequences the shared base2_to_base3 converter over the hiding string,
// prefetching up to two results ahead of the block encoder.
module base3_chunk_feeder
    import base3_chunk_feeder_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [STR_BITS-1:0] hiding_string,
    output logic                conv_en,
    output logic [CHUNK_W-1:0]  conv_in,
    input  logic                conv_done,
    input  logic [OUT_W-1:0]    conv_out,
    input  logic                chunk_req,
    output logic                chunk_valid,
    output logic [OUT_W-1:0]    chunk_data,
    output logic [IDX_W-1:0]    chunk_idx,
    output logic                busy,
    output logic                exhausted,
    output logic                underrun
);

    feed_state_t      state;
    logic [PTR_W-1:0] ptr;
    logic [1:0]       count;
    logic [1:0]       count_nx;
    logic             push;
    logic             pop;

    // A done arriving with start (abort) or outside LAUNCH is dropped.
    assign push     = (state == S_LAUNCH) && conv_done && !start;
    assign pop      = chunk_req && chunk_valid;
    assign count_nx = count + {1'b0, push} - {1'b0, pop};
    assign conv_in  = hiding_string[ptr[IDX_W-1:0]*CHUNK_W +: CHUNK_W];
    assign busy     = (state != S_IDLE) && (state != S_DONE);

    chunk_buf2 u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .push  (push),
        .pop   (pop),
        .din   (conv_out),
        .valid (chunk_valid),
        .dout  (chunk_data),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            conv_en   <= 1'b0;
            chunk_idx <= '0;
            exhausted <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (pop) chunk_idx <= chunk_idx + IDX_W'(1);
            if (chunk_req && !chunk_valid) underrun <= 1'b1;
            if (start) begin
                ptr       <= '0;
                chunk_idx <= '0;
                exhausted <= 1'b0;
                underrun  <= 1'b0;
                // Abort holds conv_en low a cycle so the restart is a fresh edge.
                conv_en   <= !busy;
                state     <= busy ? S_ABORT : S_LAUNCH;
            end else begin
                unique case (state)
                    S_IDLE: ;
                    S_LAUNCH: begin
                        if (conv_done) begin
                            conv_en <= 1'b0;
                            ptr     <= ptr + PTR_W'(1);
                            state   <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (ptr == PTR_END)       state <= S_DRAIN;
                        else if (count_nx == 2'd2) state <= S_HOLD;
                        else                       state <= S_GAP;
                    end
                    S_GAP: begin
                        conv_en <= 1'b1;
                        state   <= S_LAUNCH;
                    end
                    S_HOLD: begin
                        if (count_nx <= 2'd1) begin
                            conv_en <= 1'b1;
                            state   <= S_LAUNCH;
                        end
                    end
                    S_DRAIN: begin
                        if (count_nx == 2'd0) begin
                            exhausted <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                    S_DONE: ;
                    S_ABORT: begin
                        conv_en <= 1'b1;
                        state   <= S_LAUNCH;
                    end
                endcase
            end
        end
    end

endmodule
